_shift_reg_rs: RTL and testbench

- Parameterised universal shift register built from synchronous-set/clear register bits, with a shift counter and full flag.
- Sits directly upstream of the single-bit set/clear flip-flop stage: its serial outputs and parallel word feed those bit cells.
- Serial data is accumulated into a word, and the block reports when WIDTH bits have been shifted in since the last load or clear.

---
 rtl/_shift_reg_rs.sv | 94 +++++++++
 tb/tb__shift_reg_rs.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/_shift_reg_rs.sv
// _shift_reg_rs: universal shift register with synchronous set/clear, saturating shift counter and full flag.
// Optional build macro ROTATE_EN: shifts recirculate the outgoing bit instead of taking si_l/si_r.
module _shift_reg_rs #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_n,
  input  logic             clr_n,
  input  logic [1:0]       op,
  input  logic             si_l,
  input  logic             si_r,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic [CW-1:0]    cnt,
  output logic             full
);

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Shift count sticks at WIDTH so full stays asserted through further shifts.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v, input logic fill);
    return {v[WIDTH-2:0], fill};
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v, input logic fill);
    return {fill, v[WIDTH-1:1]};
  endfunction

  logic fill_l;
  logic fill_r;

`ifdef ROTATE_EN
  assign fill_l = q[WIDTH-1];
  assign fill_r = q[0];
  logic unused_si;
  assign unused_si = si_l ^ si_r;
`else
  assign fill_l = si_l;
  assign fill_r = si_r;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (!clr_n) begin
      q   <= '0;
      cnt <= '0;
    end else if (!set_n) begin
      q   <= '1;
      cnt <= '0;
    end else begin
      unique case (op)
        OP_LOAD: begin
          q   <= d_in;
          cnt <= '0;
        end
        OP_SHL: begin
          q   <= shl(q, fill_l);
          cnt <= sat_inc(cnt);
        end
        OP_SHR: begin
          q   <= shr(q, fill_r);
          cnt <= sat_inc(cnt);
        end
        OP_HOLD: begin
          q   <= q;
          cnt <= cnt;
        end
        default: begin
          q   <= q;
          cnt <= cnt;
        end
      endcase
    end
  end

  assign so_l = q[WIDTH-1];
  assign so_r = q[0];
  assign full = (cnt == CNT_MAX);

endmodule

// File: tb/tb__shift_reg_rs.sv
// Scoreboard bench for _shift_reg_rs: driver pushes model expectations, monitor pops after each clock edge.
module tb__shift_reg_rs;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         set_n = 1'b1;
  logic         clr_n = 1'b1;
  logic [1:0]   op = 2'b00;
  logic         si_l = 1'b0;
  logic         si_r = 1'b0;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] q;
  logic         so_l;
  logic         so_r;
  logic [3:0]   cnt;
  logic         full;

  _shift_reg_rs #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .set_n(set_n), .clr_n(clr_n), .op(op),
    .si_l(si_l), .si_r(si_r), .d_in(d_in), .q(q), .so_l(so_l), .so_r(so_r),
    .cnt(cnt), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q;
    logic [3:0]   cnt;
    logic         full;
    logic         so_l;
    logic         so_r;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: bit list (index 0 = LSB) plus a plain integer shift count.
  bit m_bits[$];
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_bits.delete();
    for (int i = 0; i < W; i++) m_bits.push_back(1'b0);
    m_cnt = 0;
  endfunction

  function automatic logic [W-1:0] m_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m_bits[i];
    return v;
  endfunction

  function automatic void m_apply(input logic c_n, input logic s_n, input logic [1:0] o,
                                  input logic sl, input logic sr, input logic [W-1:0] d);
    bit fill;
    if (!c_n) begin
      for (int i = 0; i < W; i++) m_bits[i] = 1'b0;
      m_cnt = 0;
    end else if (!s_n) begin
      for (int i = 0; i < W; i++) m_bits[i] = 1'b1;
      m_cnt = 0;
    end else if (o == 2'd3) begin
      for (int i = 0; i < W; i++) m_bits[i] = d[i];
      m_cnt = 0;
    end else if (o == 2'd1) begin
`ifdef ROTATE_EN
      fill = m_bits[W-1];
`else
      fill = sl;
`endif
      void'(m_bits.pop_back());
      m_bits.push_front(fill);
      m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
    end else if (o == 2'd2) begin
`ifdef ROTATE_EN
      fill = m_bits[0];
`else
      fill = sr;
`endif
      void'(m_bits.pop_front());
      m_bits.push_back(fill);
      m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
    end
  endfunction

  // Drive one cycle at the falling edge; optionally pulse reset before the rising edge.
  task automatic step(input logic c_n, input logic s_n, input logic [1:0] o,
                      input logic sl, input logic sr, input logic [W-1:0] d, input bit pulse_rst);
    exp_t e;
    logic [W-1:0] v;
    @(negedge clk);
    clr_n = c_n; set_n = s_n; op = o; si_l = sl; si_r = sr; d_in = d;
    if (pulse_rst) begin
      #1 reset = 1'b1;
      m_reset();
      #1;
      chk("async_rst_q", q, 0);
      chk("async_rst_cnt", cnt, 0);
      #1 reset = 1'b0;
    end
    m_apply(c_n, s_n, o, sl, sr, d);
    v = m_vec();
    e.q = v;
    e.cnt = 4'(m_cnt);
    e.full = (m_cnt == W);
    e.so_l = v[W-1];
    e.so_r = v[0];
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge produces a new register state to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_q", q, e.q);
        chk("sb_cnt", cnt, e.cnt);
        chk("sb_full", full, e.full);
        chk("sb_so_l", so_l, e.so_l);
        chk("sb_so_r", so_r, e.so_r);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fill_seq;
    logic [1:0] ro;
    int r;
    m_reset();
    #1 reset = 1'b1;
    #2;
    chk("reset_q", q, 0);
    chk("reset_cnt", cnt, 0);
    chk("reset_full", full, 0);
    @(negedge clk);
    reset = 1'b0;

    // Mid-cycle reset overrides a pending load
    step(1, 1, 2'd3, 0, 0, 8'h3C, 0);
    settle();
    @(negedge clk);
    op = 2'd3; d_in = 8'hA5;
    #2 reset = 1'b1;
    m_reset();
    #1;
    chk("midrst_q", q, 8'h00);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_full", full, 0);
    settle();
    chk("rst_held_q", q, 8'h00);
    reset = 1'b0;
    step(1, 1, 2'd3, 0, 0, 8'hA5, 0);
    settle();
    chk("load_a5_q", q, 8'hA5);
    chk("load_a5_cnt", cnt, 0);

    // Left fill
    step(0, 1, 2'd0, 0, 0, 8'h00, 0);
    fill_seq = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step(1, 1, 2'd1, fill_seq[i], 0, 8'h00, 0);
    settle();
    chk("fill_q", q, 8'hB2);
    chk("fill_cnt", cnt, 8);
    chk("fill_full", full, 1);
    step(1, 1, 2'd1, 1, 0, 8'h00, 0);
    settle();
    chk("fill9_q", q, 8'h65);
    chk("fill9_cnt", cnt, 8);

    // Right shift and serial out
    step(1, 1, 2'd3, 0, 0, 8'h81, 0);
    settle();
    @(negedge clk);
    chk("so_r_before", so_r, 1);
    step(1, 1, 2'd2, 0, 0, 8'h00, 0);
    settle();
    chk("shr1_q", q, 8'h40);
    step(1, 1, 2'd2, 0, 0, 8'h00, 0);
    settle();
    chk("shr2_q", q, 8'h20);
    chk("shr2_cnt", cnt, 2);

    // Set/clear precedence
    step(1, 1, 2'd3, 0, 0, 8'h3C, 0);
    step(0, 0, 2'd1, 1, 0, 8'h00, 0);
    settle();
    chk("clr_wins_q", q, 8'h00);
    chk("clr_wins_cnt", cnt, 0);
    step(1, 0, 2'd1, 1, 0, 8'h00, 0);
    settle();
    chk("set_q", q, 8'hFF);
    chk("set_cnt", cnt, 0);
    chk("set_full", full, 0);

    // Hold from 5A with cnt 3 (D0 shifted right with 0,1,0)
    step(1, 1, 2'd3, 0, 0, 8'hD0, 0);
    step(1, 1, 2'd2, 0, 0, 8'h00, 0);
    step(1, 1, 2'd2, 0, 1, 8'h00, 0);
    step(1, 1, 2'd2, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 2'd0, i[0], ~i[0], 8'h00, 0);
      settle();
      chk("hold_q", q, 8'h5A);
      chk("hold_cnt", cnt, 3);
    end

    // Rotate versus serial-fill behaviour
    step(1, 1, 2'd3, 0, 0, 8'h81, 0);
    step(1, 1, 2'd1, 0, 0, 8'h00, 0);
    settle();
`ifdef ROTATE_EN
    chk("rot1_q", q, 8'h03);
`else
    chk("rot1_q", q, 8'h02);
`endif
    for (int i = 0; i < 7; i++) step(1, 1, 2'd1, 0, 0, 8'h00, 0);
    settle();
`ifdef ROTATE_EN
    chk("rot8_q", q, 8'h81);
`else
    chk("rot8_q", q, 8'h00);
`endif
    chk("rot8_full", full, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      ro = (r < 70) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
      step((r % 23) != 0, (r % 17) != 0, ro, 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 59) == 0);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
